prio_mux_pipe: RTL and testbench
================================

Name: prio_mux_pipe

Overview:
Parametrised, registered N-way priority selector for the exercise datapath family. It picks one of NCH valid input channels of WIDTH bits each, using fixed priority with channel 0 highest. The chosen word goes into a single output register with a valid/ready handshake, so backpressure propagates to the inputs. It replaces hand-nested if/else select chains wherever a result must be pipelined and flow-controlled.

Parameters:
WIDTH, 4, data width per channel
NCH, 6, number of input channels (>=2)
CHW, $clog2(NCH) (localparam), width of channel index

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  NCH  per-channel request; bit i = channel i
in_data  input  NCH*WIDTH  flattened channel data; channel i at [i*WIDTH +: WIDTH]
in_ready  output  NCH  per-channel accept; at most one bit high
out_valid  output  1  output register holds a word
out_data  output  WIDTH  selected word
out_ch  output  CHW  index of the channel that supplied out_data
out_ready  input  1  downstream accepts when out_valid & out_ready

Behaviour:
- Reset (sync, active-high, clk edge):
  - out_valid=0, out_data=0, out_ch=0; round-robin pointer=0 if built.
  - in_ready forced to 0 combinationally while rst=1.
- load_en = ~out_valid | out_ready (register empty, or being emptied this cycle).
- Grant (combinational, one-hot or zero):
  - grant[i]=1 for the lowest i with in_valid[i]=1 (fixed priority); no grant if all in_valid are 0.
  - in_ready = grant & {NCH{load_en}} & ~rst.
- Input transfer occurs when in_valid[i] & in_ready[i]. On that clk edge:
  - out_data <= in_data[i], out_ch <= i, out_valid <= 1.
- Output transfer occurs when out_valid & out_ready.
  - If there is no simultaneous input transfer: out_valid <= 0; out_data and out_ch hold their last values.
  - If there is a simultaneous input transfer: the register reloads with out_valid staying 1, giving full throughput of 1 word per cycle.
- Backpressure (out_valid=1, out_ready=0): out_valid, out_data and out_ch are held stable; all in_ready=0.
- Latency: 1 cycle from input transfer to out_valid.
- Channel inputs: in_valid may drop or change between cycles without a transfer. Only the grant in the cycle of the transfer matters; no lock-in.
- Simultaneous requests: exactly one channel is served per cycle; lower-priority channels wait. Starvation is permitted in fixed mode.
- Reset mid-operation: any pending output word is discarded (out_valid=0 next cycle). No input transfer occurs in the reset cycle.
- out_ch is zero-extended to CHW bits; channel indices >=NCH never appear.

Optional Feature:
Macro PRIO_MUX_RR_EN.
- Defined:
  - Adds a CHW-bit register ptr, reset 0.
  - Grant goes to the first valid channel searching ptr, ptr+1, …, NCH-1, 0, …, ptr-1 (wrap-around).
  - After each input transfer from channel g: ptr <= (g==NCH-1) ? 0 : g+1.
  - ptr holds when there is no transfer, including under backpressure.
- Not defined: fixed priority as above; no ptr register exists.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=6'b111111, out_ready=1 -> in_ready=0, out_valid=0, out_data=0, out_ch=0 throughout.
- Priority: in_valid=6'b101100, ch2=4'h3, ch3=4'h5, ch5=4'hA, out_ready=1; each served channel drops its valid after its transfer -> out_data/out_ch sequence 3/2, 5/3, A/5 on consecutive cycles, then out_valid=0.
- Backpressure: load ch0=4'h9, then out_ready=0 for 3 cycles with ch1 valid -> out_data=9, out_ch=0 stable, in_ready=0. Raise out_ready -> ch1 loaded on the same edge; out_valid stays 1.
- Mid-op reset: out_valid=1, out_ready=0, rst pulsed 1 cycle -> out_valid=0 next cycle; no in_ready during rst. (RR build: ptr returns to 0.)
- Round-robin (PRIO_MUX_RR_EN): in_valid=6'b111111 held, out_ready=1 -> out_ch sequence 0,1,2,3,4,5,0,1. Without the macro, the same stimulus gives out_ch=0 every cycle.
- Generic widths: WIDTH=8, NCH=3, only ch2 valid with 8'hC3 -> out_data=8'hC3, out_ch=2'd2 one cycle after in_ready[2].

Source files
------------

// File: rtl/prio_mux_pipe.sv
// ---------------------------------------------------------------------------
// prio_mux_pipe
//
// Registered N-way priority selector. One of NCH requesting channels is
// picked each cycle and its word is captured into a single output register
// that talks valid/ready to the downstream side. Because the register only
// loads when it is empty or being drained, backpressure reaches the inputs
// through in_ready.
//
// Parameters:
//    WIDTH  data width of each channel
//    NCH    number of input channels (must be at least 2)
//    CHW    (local) width of a channel index, $clog2(NCH)
//
// Ports:
//    clk        rising-edge clock
//    rst        synchronous active-high reset
//    in_valid   per-channel request, bit i belongs to channel i
//    in_data    flattened channel data, channel i at [i*WIDTH +: WIDTH]
//    in_ready   per-channel accept, at most one bit high
//    out_valid  output register holds a word
//    out_data   selected word
//    out_ch     index of the channel that supplied out_data
//    out_ready  downstream accepts when out_valid & out_ready
//
// Build option:
//    PRIO_MUX_RR_EN  when defined, the grant search starts at a rotating
//                    pointer instead of always at channel 0, so every
//                    requesting channel gets a turn.
// ---------------------------------------------------------------------------
module prio_mux_pipe #(
   parameter int WIDTH = 4,
   parameter int NCH   = 6
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NCH-1:0]         in_valid,
   input  logic [NCH*WIDTH-1:0]   in_data,
   output logic [NCH-1:0]         in_ready,
   output logic                   out_valid,
   output logic [WIDTH-1:0]       out_data,
   output logic [$clog2(NCH)-1:0] out_ch,
   input  logic                   out_ready
);

   localparam int CHW = $clog2(NCH);

   logic             loadEn;
   logic             inXfer;
   logic [NCH-1:0]   grant;
   logic [CHW-1:0]   grantIdx;
   logic [WIDTH-1:0] grantData;

   // The output register may take a new word when it is empty or when its
   // current word leaves on this same edge; that is what gives one word per
   // cycle under continuous flow.
   assign loadEn = ~out_valid | out_ready;

   // Only the granted channel can see ready, and never while in reset, so
   // no word is ever accepted on a reset edge.
   assign in_ready = grant & {NCH{loadEn & ~rst}};
   assign inXfer   = |in_ready;

`ifdef PRIO_MUX_RR_EN
   logic [CHW-1:0] ptr;
   int             dist;
   int             bestDist;

   // Rotating-priority grant: each requesting channel is scored by how far
   // it sits after ptr going round the ring, and the closest one wins.
   // Working with distances keeps every index a constant loop variable
   // instead of a computed wrap-around index.
   always_comb begin
      grant     = '0;
      grantIdx  = '0;
      grantData = '0;
      dist      = 0;
      bestDist  = NCH;
      for (int i = 0; i < NCH; i++) begin
         dist = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + NCH - int'(ptr));
         if (in_valid[i] && (dist < bestDist)) begin
            bestDist  = dist;
            grant     = '0;
            grant[i]  = 1'b1;
            grantIdx  = CHW'(i);
            grantData = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // The pointer moves to the channel just after the one served, wrapping
   // at the top; it only moves on an actual transfer, so stalls leave it put.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (inXfer) begin
         ptr <= (grantIdx == CHW'(NCH - 1)) ? '0 : grantIdx + 1'b1;
      end
   end
`else
   // Fixed-priority grant: scanning from the top channel down means the
   // lowest requesting channel is the last to overwrite, so channel 0 wins.
   always_comb begin
      grant     = '0;
      grantIdx  = '0;
      grantData = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (in_valid[i]) begin
            grant     = '0;
            grant[i]  = 1'b1;
            grantIdx  = CHW'(i);
            grantData = in_data[i*WIDTH +: WIDTH];
         end
      end
   end
`endif

   // Output register. A new word always wins over draining, which keeps
   // out_valid high through back-to-back transfers. When the word is taken
   // with nothing behind it, only valid drops; data and channel keep their
   // last values.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
      end else if (inXfer) begin
         out_valid <= 1'b1;
         out_data  <= grantData;
         out_ch    <= grantIdx;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_prio_mux_pipe.sv
// ---------------------------------------------------------------------------
// tb_prio_mux_pipe
//
// Self-checking bench for prio_mux_pipe. A small reference model predicts
// in_ready and which word enters the output register; predicted words go
// into a scoreboard queue and are compared while they sit in the DUT output
// register. Directed sequences from the test plan are checked against
// constant expectations. A second instance covers WIDTH=8, NCH=3.
// ---------------------------------------------------------------------------
module tb_prio_mux_pipe;

   localparam int WIDTH = 4;
   localparam int NCH   = 6;
   localparam int CHW   = 3;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NCH-1:0]       inValid;
   logic [NCH*WIDTH-1:0] inData;
   logic [NCH-1:0]       inReady;
   logic                 outValid;
   logic [WIDTH-1:0]     outData;
   logic [CHW-1:0]       outCh;
   logic                 outReady;

   logic [2:0]           inValid2;
   logic [23:0]          inData2;
   logic [2:0]           inReady2;
   logic                 outValid2;
   logic [7:0]           outData2;
   logic [1:0]           outCh2;
   logic                 outReady2;

   int                   compared   = 0;
   int                   mismatched = 0;
   logic [31:0]          sb[$];
   logic [31:0]          obs[$];
   logic                 mValid;
   int                   mPtr;

   always #5 clk = ~clk;

   prio_mux_pipe #(.WIDTH(WIDTH), .NCH(NCH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inValid),
      .in_data   (inData),
      .in_ready  (inReady),
      .out_valid (outValid),
      .out_data  (outData),
      .out_ch    (outCh),
      .out_ready (outReady)
   );

   prio_mux_pipe #(.WIDTH(8), .NCH(3)) dut2 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inValid2),
      .in_data   (inData2),
      .in_ready  (inReady2),
      .out_valid (outValid2),
      .out_data  (outData2),
      .out_ch    (outCh2),
      .out_ready (outReady2)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic [NCH-1:0] v, input logic rdy);
      rst      = r;
      inValid  = v;
      outReady = rdy;
   endtask

   task automatic setCh(input int ch, input logic [WIDTH-1:0] val);
      inData[ch*WIDTH +: WIDTH] = val;
   endtask

   function automatic logic [31:0] packWord(input logic [CHW-1:0] ch, input logic [WIDTH-1:0] d);
      return (32'(ch) << WIDTH) | 32'(d);
   endfunction

   // Reference grant: fixed priority, or first requester at/after mPtr.
   function automatic int modelGrant();
`ifdef PRIO_MUX_RR_EN
      for (int k = 0; k < NCH; k++) begin
         int c;
         c = (mPtr + k) % NCH;
         if (inValid[c]) return c;
      end
`else
      for (int i = 0; i < NCH; i++) begin
         if (inValid[i]) return i;
      end
`endif
      return -1;
   endfunction

   // One clock: check at the falling edge, advance the model at the rising
   // edge, return 1 time unit later so callers can drive and probe safely.
   task automatic runCycle();
      logic [NCH-1:0] expReady;
      logic           loadEn;
      int             g;
      @(negedge clk);
      loadEn   = !mValid || outReady;
      g        = modelGrant();
      expReady = '0;
      if (!rst && loadEn && (g >= 0)) expReady[g] = 1'b1;
      checkOutput("in_ready", 32'(inReady), 32'(expReady));
      checkOutput("out_valid", 32'(outValid), 32'(mValid));
      if (mValid) begin
         if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL sb_underflow: got word 0x%0h, expected none", packWord(outCh, outData));
         end else begin
            checkOutput("out_word", packWord(outCh, outData), sb[0]);
         end
      end
      if (!rst && outValid && outReady) obs.push_back(packWord(outCh, outData));
      @(posedge clk);
      if (rst) begin
         mValid = 1'b0;
         mPtr   = 0;
         sb.delete();
      end else begin
         if (mValid && outReady) begin
            if (sb.size() > 0) void'(sb.pop_front());
            mValid = 1'b0;
         end
         if (expReady != '0) begin
            sb.push_back((32'(g) << WIDTH) | 32'(inData[g*WIDTH +: WIDTH]));
            mValid = 1'b1;
            mPtr   = (g == NCH - 1) ? 0 : g + 1;
         end
      end
      #1;
   endtask

   initial begin
      logic [31:0] expPrio[3];
      int          expRrCh[9];

      rst       = 1'b1;
      inValid   = '0;
      inData    = '0;
      outReady  = 1'b1;
      inValid2  = '0;
      inData2   = '0;
      outReady2 = 1'b1;
      mValid    = 1'b0;
      mPtr      = 0;
      @(posedge clk);
      #1;

      // Reset held two cycles with every channel requesting.
      inData = 24'hFEDCBA;
      applyStimulus(1'b1, 6'b111111, 1'b1);
      repeat (2) begin
         runCycle();
         checkOutput("rst_out_data", 32'(outData), 32'd0);
         checkOutput("rst_out_ch", 32'(outCh), 32'd0);
      end

      // Fixed priority among channels 2, 3 and 5.
      inData = '0;
      setCh(2, 4'h3);
      setCh(3, 4'h5);
      setCh(5, 4'hA);
      obs.delete();
      applyStimulus(1'b0, 6'b101100, 1'b1);
      runCycle();
      inValid[2] = 1'b0;
      runCycle();
      inValid[3] = 1'b0;
      runCycle();
      inValid[5] = 1'b0;
      runCycle();
      runCycle();
      expPrio = '{32'h23, 32'h35, 32'h5A};
      checkOutput("prio_count", 32'(obs.size()), 32'd3);
      for (int i = 0; i < 3; i++) begin
         if (i < obs.size()) checkOutput("prio_word", obs[i], expPrio[i]);
      end
      checkOutput("prio_idle", 32'(outValid), 32'd0);

      // Backpressure: word from ch0 held while ch1 waits.
      setCh(0, 4'h9);
      applyStimulus(1'b0, 6'b000001, 1'b1);
      runCycle();
      setCh(1, 4'h7);
      applyStimulus(1'b0, 6'b000010, 1'b0);
      repeat (3) begin
         runCycle();
         checkOutput("bp_data", 32'(outData), 32'h9);
         checkOutput("bp_ch", 32'(outCh), 32'd0);
         checkOutput("bp_ready", 32'(inReady), 32'd0);
      end
      outReady = 1'b1;
      runCycle();
      checkOutput("bp_reload_valid", 32'(outValid), 32'd1);
      checkOutput("bp_reload_word", packWord(outCh, outData), 32'h17);
      applyStimulus(1'b0, 6'b000000, 1'b1);
      runCycle();
      checkOutput("bp_drain", 32'(outValid), 32'd0);

      // Reset while a word is stuck in the register.
      setCh(4, 4'h6);
      applyStimulus(1'b0, 6'b010000, 1'b1);
      runCycle();
      applyStimulus(1'b1, 6'b010000, 1'b0);
      runCycle();
      checkOutput("mid_rst_valid", 32'(outValid), 32'd0);
      checkOutput("mid_rst_data", 32'(outData), 32'd0);

      // All channels requesting continuously straight after that reset.
      for (int i = 0; i < NCH; i++) setCh(i, WIDTH'(i + 1));
      obs.delete();
      applyStimulus(1'b0, 6'b111111, 1'b1);
      repeat (9) runCycle();
      applyStimulus(1'b0, 6'b000000, 1'b1);
      runCycle();
      runCycle();
`ifdef PRIO_MUX_RR_EN
      expRrCh = '{0, 1, 2, 3, 4, 5, 0, 1, 2};
`else
      expRrCh = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
      checkOutput("all_req_count", 32'(obs.size()), 32'd9);
      for (int i = 0; i < 9; i++) begin
         if (i < obs.size()) begin
            checkOutput("all_req_ch", obs[i] >> WIDTH, 32'(expRrCh[i]));
            checkOutput("all_req_data", obs[i] & 32'hF, 32'(expRrCh[i] + 1));
         end
      end
      checkOutput("all_req_idle", 32'(outValid), 32'd0);

      // Second geometry: WIDTH=8, NCH=3, only ch2 requesting.
      inValid2 = 3'b100;
      inData2  = 24'hC3_00_00;
      @(negedge clk);
      checkOutput("gen_in_ready", 32'(inReady2), 32'h4);
      checkOutput("gen_pre_valid", 32'(outValid2), 32'd0);
      @(posedge clk);
      #1;
      inValid2 = 3'b000;
      checkOutput("gen_valid", 32'(outValid2), 32'd1);
      checkOutput("gen_data", 32'(outData2), 32'hC3);
      checkOutput("gen_ch", 32'(outCh2), 32'd2);
      @(posedge clk);
      #1;
      checkOutput("gen_drain", 32'(outValid2), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
